// File: rtl/pc_gen_rv32i_pkg.sv
// Shared constants and encodings for the RV32I program-counter generator.
package pc_gen_rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HALT = 2'b01,
    S_TRAP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10
  } trap_cause_e;

endpackage

// File: rtl/pc_gen_rv32i.sv
// RV32I fetch PC generator: next-PC selection, halt/trap control and retire counter.
module pc_gen_rv32i
  import pc_gen_rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     ROM_AW   = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic            halted,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] retired
);

  // One past the last valid byte address; 33 bits so ROM_AW up to 30 does not overflow.
  localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(4) << ROM_AW;

  state_e          state_q, state_d;
  trap_cause_e     cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            halted_q, trap_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            target_oor;
  logic            seq_oor;

  assign pc_plus4    = pc_q + XLEN'(4);
  assign rel_target  = pc_q + imm;
  assign jalr_target = (rs1_data + imm) & ~XLEN'(1);
  assign seq_oor     = {1'b0, pc_plus4} >= PC_LIMIT;
  assign target_oor  = {1'b0, target} >= PC_LIMIT;

  // Redirect priority: jalr > jal > branch > sequential.
  always_comb begin
    redirect = 1'b0;
    target   = pc_plus4;
    if (jalr) begin
      redirect = 1'b1;
      target   = jalr_target;
    end else if (jal || branch_taken) begin
      redirect = 1'b1;
      target   = rel_target;
    end
  end

  // Next-state, next-PC and retire-count logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    unique case (state_q)
      S_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            retired_d = retired_q + XLEN'(1);
            state_d   = S_HALT;
          end else if (redirect && target[1]) begin
            state_d = S_TRAP;
            cause_d = CAUSE_MISALIGN;
          end else if (target_oor) begin
            state_d = S_TRAP;
            cause_d = CAUSE_RANGE;
          end else begin
            pc_d      = target;
            retired_d = retired_q + XLEN'(1);
          end
        end
      end
      S_HALT: begin
        if (resume) begin
          if (seq_oor) begin
            state_d = S_TRAP;
            cause_d = CAUSE_RANGE;
          end else begin
            pc_d    = pc_plus4;
            state_d = S_RUN;
          end
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Status flags are registered alongside the state so they carry no input path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      cause_q   <= CAUSE_NONE;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
      halted_q  <= (state_d == S_HALT);
      trap_q    <= (state_d == S_TRAP);
    end
  end

  assign PC         = pc_q;
  assign PC_PLUS4   = pc_plus4;
  assign retired    = retired_q;
  assign halted     = halted_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_pc_gen_rv32i.sv
// Bench for pc_gen_rv32i: directed scenarios plus randomized run against a reference model.
module tb_pc_gen_rv32i;

  logic        clock = 1'b0;
  logic        reset, stall, branch_taken, jal, jalr, halt_req, resume;
  logic [31:0] imm, rs1_data;
  logic [31:0] PC, PC_PLUS4, retired;
  logic        halted, trap;
  logic [1:0]  trap_cause;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=run 1=halt 2=trap
  int          m_mode;
  logic [31:0] m_pc, m_ret;
  logic [1:0]  m_cause;
  localparam longint unsigned LIMIT = 64'd4 << 6;

  pc_gen_rv32i dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .jal(jal), .jalr(jalr), .imm(imm), .rs1_data(rs1_data),
    .halt_req(halt_req), .resume(resume), .PC(PC), .PC_PLUS4(PC_PLUS4),
    .halted(halted), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clock = ~clock;

  function automatic logic [67:0] obs();
    return {PC, retired, halted, trap, trap_cause};
  endfunction

  function automatic logic [67:0] model_obs();
    return {m_pc, m_ret, (m_mode == 1), (m_mode == 2), m_cause};
  endfunction

  task automatic model_step();
    longint unsigned t;
    logic [31:0] tgt;
    logic        redir;
    if (reset) begin
      m_pc = 32'h0; m_mode = 0; m_ret = 0; m_cause = 2'b00;
      return;
    end
    if (m_mode == 1) begin
      if (resume) begin
        t = longint'(m_pc) + 4;
        if ((t % (64'd1 << 32)) >= LIMIT) begin m_mode = 2; m_cause = 2'b10; end
        else begin m_pc = m_pc + 4; m_mode = 0; end
      end
      return;
    end
    if (m_mode == 2 || stall) return;
    if (halt_req) begin m_ret = m_ret + 1; m_mode = 1; return; end
    redir = jalr | jal | branch_taken;
    if (jalr)                     tgt = (rs1_data + imm) & 32'hFFFF_FFFE;
    else if (jal || branch_taken) tgt = m_pc + imm;
    else                          tgt = m_pc + 4;
    if (redir && ((tgt % 4) >= 2)) begin m_mode = 2; m_cause = 2'b01; end
    else if (longint'(tgt) >= LIMIT) begin m_mode = 2; m_cause = 2'b10; end
    else begin m_pc = tgt; m_ret = m_ret + 1; end
  endtask

  task automatic drive(input logic rst, input logic st, input logic br, input logic j,
                       input logic jr, input logic [31:0] im, input logic [31:0] rs,
                       input logic hr, input logic rsm);
    reset = rst; stall = st; branch_taken = br; jal = j; jalr = jr;
    imm = im; rs1_data = rs; halt_req = hr; resume = rsm;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    tick();
    idle();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 1, 32'h40, 32'h80, 1, 1);
    tick();
    idle();
    total++;
    if (obs() !== {32'h0, 32'd0, 1'b0, 1'b0, 2'b00}) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", obs(), {32'h0, 32'd0, 4'b0});
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (PC !== 32'(4*i) || retired !== 32'(i) || PC_PLUS4 !== 32'(4*i+4)) begin
        bad++;
        $display("FAIL seq_%0d got pc=%h ret=%0d p4=%h exp pc=%h ret=%0d p4=%h",
                 i, PC, retired, PC_PLUS4, 32'(4*i), i, 32'(4*i+4));
      end
      tick();
    end
  endtask

  task automatic test_jal_stall();
    do_reset();
    drive(0, 0, 0, 1, 0, 32'h10, 32'h0, 0, 0); tick();
    drive(0, 1, 0, 1, 0, 32'h20, 32'h0, 1, 0); tick();
    total++;
    if (obs() !== {32'h10, 32'd1, 4'b0}) begin
      bad++; $display("FAIL jal_stall got=%h exp=%h", obs(), {32'h10, 32'd1, 4'b0});
    end
    drive(0, 0, 0, 1, 0, 32'h20, 32'h0, 0, 0); tick();
    total++;
    if (obs() !== {32'h30, 32'd2, 4'b0}) begin
      bad++; $display("FAIL jal_taken got=%h exp=%h", obs(), {32'h30, 32'd2, 4'b0});
    end
  endtask

  task automatic test_jalr();
    do_reset();
    drive(0, 0, 0, 1, 0, 32'h8, 32'h0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 32'h0, 32'h41, 0, 0); tick();
    total++;
    if (obs() !== {32'h40, 32'd2, 4'b0}) begin
      bad++; $display("FAIL jalr_bit0 got=%h exp=%h", obs(), {32'h40, 32'd2, 4'b0});
    end
    drive(0, 0, 1, 1, 1, 32'h4, 32'h80, 0, 0); tick();
    total++;
    if (obs() !== {32'h84, 32'd3, 4'b0}) begin
      bad++; $display("FAIL jalr_priority got=%h exp=%h", obs(), {32'h84, 32'd3, 4'b0});
    end
  endtask

  task automatic test_misalign();
    do_reset();
    drive(0, 0, 0, 1, 0, 32'h20, 32'h0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 32'h6, 32'h0, 0, 0); tick();
    total++;
    if (obs() !== {32'h20, 32'd1, 1'b0, 1'b1, 2'b01}) begin
      bad++; $display("FAIL misalign_trap got=%h exp=%h", obs(), {32'h20, 32'd1, 4'b0101});
    end
    drive(0, 0, 0, 1, 0, 32'h4, 32'h0, 0, 1); tick();
    total++;
    if (obs() !== {32'h20, 32'd1, 1'b0, 1'b1, 2'b01}) begin
      bad++; $display("FAIL trap_absorb got=%h exp=%h", obs(), {32'h20, 32'd1, 4'b0101});
    end
    do_reset();
    total++;
    if (obs() !== {32'h0, 32'd0, 4'b0}) begin
      bad++; $display("FAIL trap_reset got=%h exp=%h", obs(), {32'h0, 32'd0, 4'b0});
    end
  endtask

  task automatic test_range_halt();
    do_reset();
    drive(0, 0, 0, 1, 0, 32'hFC, 32'h0, 0, 0); tick();
    idle(); tick();
    total++;
    if (obs() !== {32'hFC, 32'd1, 1'b0, 1'b1, 2'b10}) begin
      bad++; $display("FAIL range_trap got=%h exp=%h", obs(), {32'hFC, 32'd1, 4'b0110});
    end
    do_reset();
    drive(0, 0, 0, 1, 0, 32'h14, 32'h0, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 32'h40, 32'h0, 1, 0); tick();
    total++;
    if (obs() !== {32'h14, 32'd2, 1'b1, 1'b0, 2'b00}) begin
      bad++; $display("FAIL halt_enter got=%h exp=%h", obs(), {32'h14, 32'd2, 4'b1000});
    end
    drive(0, 0, 1, 1, 1, 32'h40, 32'h40, 1, 0); tick();
    total++;
    if (obs() !== {32'h14, 32'd2, 1'b1, 1'b0, 2'b00}) begin
      bad++; $display("FAIL halt_hold got=%h exp=%h", obs(), {32'h14, 32'd2, 4'b1000});
    end
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1); tick();
    total++;
    if (obs() !== {32'h18, 32'd2, 4'b0}) begin
      bad++; $display("FAIL halt_resume got=%h exp=%h", obs(), {32'h18, 32'd2, 4'b0});
    end
    idle(); tick();
    total++;
    if (obs() !== {32'h1C, 32'd3, 4'b0}) begin
      bad++; $display("FAIL after_resume got=%h exp=%h", obs(), {32'h1C, 32'd3, 4'b0});
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    drive(0, 0, 0, 1, 0, 32'hFC, 32'h0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0); tick();
    drive(1, 1, 0, 0, 0, 32'h0, 32'h0, 0, 1); tick();
    total++;
    if (obs() !== {32'h0, 32'd0, 4'b0}) begin
      bad++; $display("FAIL reset_mid_halt got=%h exp=%h", obs(), {32'h0, 32'd0, 4'b0});
    end
    drive(1, 0, 0, 1, 0, 32'h40, 32'h0, 0, 0); tick();
    idle();
    total++;
    if (obs() !== {32'h0, 32'd0, 4'b0}) begin
      bad++; $display("FAIL reset_mid_jal got=%h exp=%h", obs(), {32'h0, 32'd0, 4'b0});
    end
  endtask

  task automatic test_random();
    logic [31:0] im;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      im = 32'($urandom_range(0, 40) * 4) - 32'd80;
      if ($urandom_range(0, 7) == 0) im = im + 32'd2;
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, im, 32'($urandom_range(0, 300)),
            $urandom_range(0, 12) == 0, $urandom_range(0, 3) == 0);
      tick();
      total++;
      if (obs() !== model_obs() || PC_PLUS4 !== m_pc + 32'd4) begin
        bad++;
        $display("FAIL random_%0d got=%h p4=%h exp=%h p4=%h", n, obs(), PC_PLUS4,
                 model_obs(), m_pc + 32'd4);
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_sequential();
    test_jal_stall();
    test_jalr();
    test_misalign();
    test_range_halt();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen_rv32i.md
PC_GEN_RV32I -- requirements
Module: pc_gen_rv32i

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter ROM_AW, default 6: instruction ROM word-address width; valid PC range 0 .. (4<<ROM_AW)-4.
REQ-003 clock  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hold PC, state and counter this cycle.
REQ-006 branch_taken  in  1  conditional branch resolved taken.
REQ-007 jal  in  1  current instruction is JAL.
REQ-008 jalr  in  1  current instruction is JALR.
REQ-009 imm  in  32  sign-extended immediate of current instruction.
REQ-010 rs1_data  in  32  rs1 operand, used by JALR.
REQ-011 halt_req  in  1  current instruction is ECALL/EBREAK.
REQ-012 resume  in  1  leave HALT.
REQ-013 PC  out  32  registered fetch address to the instruction ROM.
REQ-014 PC_PLUS4  out  32  PC+4, combinational, link value for JAL/JALR.
REQ-015 halted  out  1  high in HALT.
REQ-016 trap  out  1  high in TRAP.
REQ-017 trap_cause  out  2  01 misaligned target, 10 out-of-range target, 00 none.
REQ-018 retired  out  32  retired-instruction count.

Function
REQ-019 PC SHALL be a register driven only from the rising edge; the ROM samples it on the falling edge, so PC is stable for the second half-cycle.
REQ-020 States: RUN, HALT, TRAP.
REQ-021 RUN next-PC priority: stall > halt_req > jalr > jal > branch_taken > sequential.
REQ-022 Targets: branch/JAL = PC+imm; JALR = (rs1_data+imm) with bit0 cleared; sequential = PC+4; all modulo 2^32.
REQ-023 stall=1 in RUN: PC, state, retired unchanged; halt_req and redirects ignored.
REQ-024 halt_req=1, stall=0 in RUN: PC held, retired+1, state -> HALT next cycle; simultaneous redirects ignored.
REQ-025 Selected redirect target with bit1 set: PC held, state -> TRAP, trap_cause=01, retired unchanged.
REQ-026 Target (redirect or sequential) >= 4<<ROM_AW: PC held, state -> TRAP, trap_cause=10; misaligned takes priority if both.
REQ-027 Otherwise in RUN: PC <= next-PC, retired+1 (wraps 32'hFFFF_FFFF -> 0).
REQ-028 HALT: PC and retired held; resume=1 -> PC <= PC+4, state RUN; range check of REQ-026 applies to that PC+4; all other inputs ignored.
REQ-029 TRAP: absorbing until reset; PC, retired and trap_cause held; resume ignored.
REQ-030 halted, trap are decoded from registered state (no combinational path from inputs).

Reset
REQ-031 reset=1 at a rising edge: PC=RESET_PC, state=RUN, retired=0, trap_cause=00, halted=0, trap=0, regardless of state or stall.
REQ-032 Reset asserted mid-redirect or mid-HALT SHALL discard that operation entirely.
REQ-033 First instruction fetched after reset release is at RESET_PC.

Structure
REQ-034 Shared package SHALL hold the state encoding, trap_cause codes, RESET_PC default and instruction width constant (32).
REQ-035 No sub-module is required; next-PC selection and range checking stay in this module.

Verification
REQ-036 Reset then 5 free cycles -> PC 0,4,8,12,16; retired 0..4; PC_PLUS4 = PC+4 every cycle.
REQ-037 PC=0x10, jal=1, imm=0x20 -> PC=0x30 next cycle; same cycle with stall=1 -> PC stays 0x10, retired unchanged.
REQ-038 PC=0x08, jalr=1, rs1_data=0x41, imm=0 -> PC=0x40; jalr+jal+branch together -> jalr target wins.
REQ-039 PC=0x20, branch_taken=1, imm=0x06 -> TRAP, trap_cause=01, PC stays 0x20; resume=1 no effect; reset -> PC=0, RUN.
REQ-040 PC=0xFC, ROM_AW=6, sequential -> TRAP, trap_cause=10; halt_req at PC=0x14 -> halted=1, PC 0x14 held, resume -> PC=0x18.
